// File: rtl/clkdiv_pkg.sv
// Shared defaults, divisor type and per-edge action codes for the clock divider.
package clkdiv_pkg;

  localparam int CLKDIV_DIV_W   = 8;
  localparam int CLKDIV_DEF_DIV = 2;

  typedef logic [CLKDIV_DIV_W-1:0] div_t;

  // What a channel does on a given clock edge (reset handled separately)
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,  // counting paused, loads still captured
    ACT_COUNT = 2'd1,  // advance counter inside the period
    ACT_APPLY = 2'd2   // period boundary: take new divisor, restart at cnt 0
  } act_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, pending flag, output flops.
module clk_div_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = CLKDIV_DIV_W,
  parameter int DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic             iClkIN,
  input  logic             reset,
  input  logic             iEn,
  input  logic             iSync,
  input  logic             iLoad,
  input  logic [DIV_W-1:0] iDivisor,
  output logic             oDiv,
  output logic             oTick,
  output logic             oPending
);

  localparam logic [DIV_W-1:0] L_DEF = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] r_cnt, r_active, r_shadow;
  logic             r_pending, r_div, r_tick;

  logic [DIV_W-1:0] w_byp, w_cnt_inc;
  logic             w_wrap;
  act_e             w_act;

  // Next-count and action select; the load value bypasses the shadow so a
  // load landing on a boundary edge takes effect immediately.
  always_comb begin
    w_byp     = iLoad ? iDivisor : r_shadow;
    w_cnt_inc = (r_cnt == r_active - 1'b1) ? '0 : r_cnt + 1'b1;
    w_wrap    = (w_cnt_inc == '0);
    w_act     = ACT_COUNT;
    if (iSync || r_active == '0) w_act = ACT_APPLY;
    else if (!iEn)               w_act = ACT_HOLD;
    else if (w_wrap)             w_act = ACT_APPLY;
  end

  // Channel state and registered outputs
  always_ff @(posedge iClkIN) begin
    if (reset) begin
      r_cnt     <= L_DEF - 1'b1;
      r_active  <= L_DEF;
      r_shadow  <= L_DEF;
      r_pending <= 1'b0;
      r_div     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      case (w_act)
        ACT_APPLY: begin
          // Shadow equals active whenever nothing is pending, so applying the
          // bypassed shadow is correct whether or not a load is outstanding.
          r_cnt     <= '0;
          r_active  <= w_byp;
          r_shadow  <= w_byp;
          r_pending <= 1'b0;
          r_tick    <= (w_byp != '0);
          r_div     <= (w_byp != '0);
        end
        ACT_COUNT: begin
          r_cnt     <= w_cnt_inc;
          r_shadow  <= w_byp;
          r_pending <= r_pending | iLoad;
          r_tick    <= 1'b0;
          r_div     <= (w_cnt_inc < (r_active >> 1));
        end
        default: begin
          r_shadow  <= w_byp;
          r_pending <= r_pending | iLoad;
          r_tick    <= 1'b0;
        end
      endcase
    end
  end

  assign oDiv     = r_div;
  assign oTick    = r_tick;
  assign oPending = r_pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: slices the divisor bus and
// fans the global controls out to NCH identical channels.
module clk_div_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DIV_W   = CLKDIV_DIV_W,
  parameter int DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic                 iClkIN,
  input  logic                 reset,
  input  logic                 iEn,
  input  logic                 iSync,
  input  logic [NCH-1:0]       iLoad,
  input  logic [NCH*DIV_W-1:0] iDivisor,
  output logic [NCH-1:0]       oDiv,
  output logic [NCH-1:0]       oTick,
  output logic [NCH-1:0]       oPending
);

  logic [NCH-1:0][DIV_W-1:0] w_div_in;
  assign w_div_in = iDivisor;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .iClkIN  (iClkIN),
      .reset   (reset),
      .iEn     (iEn),
      .iSync   (iSync),
      .iLoad   (iLoad[g]),
      .iDivisor(w_div_in[g]),
      .oDiv    (oDiv[g]),
      .oTick   (oTick[g]),
      .oPending(oPending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios then random
// traffic, all checked each cycle against a period/phase reference model.
module tb_clk_div_multi;
  localparam int NCH     = 4;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 2;

  logic                 iClkIN = 1'b0;
  logic                 reset, iEn, iSync;
  logic [NCH-1:0]       iLoad;
  logic [NCH*DIV_W-1:0] iDivisor;
  logic [NCH-1:0]       oDiv, oTick, oPending;

  int total = 0;
  int bad   = 0;

  // Reference model: each channel sits at phase ph within a period of length n
  int             m_ph [NCH];
  int             m_n  [NCH];
  int             m_sh [NCH];
  logic [NCH-1:0] m_div, m_tick, m_pend;

  clk_div_multi #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .iClkIN(iClkIN), .reset(reset), .iEn(iEn), .iSync(iSync),
    .iLoad(iLoad), .iDivisor(iDivisor),
    .oDiv(oDiv), .oTick(oTick), .oPending(oPending)
  );

  always #5 iClkIN = ~iClkIN;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  // Start a fresh period of length n at phase 0
  function automatic void m_start(int i, int n);
    m_n[i] = n; m_sh[i] = n; m_pend[i] = 1'b0; m_ph[i] = 0;
    m_tick[i] = (n != 0);
    m_div[i]  = (n != 0);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  function automatic void model_edge();
    for (int i = 0; i < NCH; i++) begin
      int newv;
      newv = iLoad[i] ? int'(iDivisor[i*DIV_W +: DIV_W]) : m_sh[i];
      if (reset) begin
        m_ph[i] = DEF_DIV - 1; m_n[i] = DEF_DIV; m_sh[i] = DEF_DIV;
        m_pend[i] = 0; m_div[i] = 0; m_tick[i] = 0;
      end else if (iSync || m_n[i] == 0) begin
        m_start(i, newv);
      end else if (!iEn) begin
        m_sh[i] = newv; m_pend[i] = m_pend[i] | iLoad[i]; m_tick[i] = 0;
      end else if ((m_ph[i] + 1) % m_n[i] == 0) begin
        m_start(i, newv);
      end else begin
        m_ph[i] = m_ph[i] + 1;
        m_sh[i] = newv; m_pend[i] = m_pend[i] | iLoad[i];
        m_tick[i] = 0;
        m_div[i]  = (m_ph[i] < m_n[i] / 2);
      end
    end
  endfunction

  task automatic step();
    @(posedge iClkIN);
    model_edge();
    #1;
    chk("div", oDiv, m_div);
    chk("tick", oTick, m_tick);
    chk("pend", oPending, m_pend);
    iLoad = '0; iSync = 1'b0; reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input int ch, input int v);
    iLoad[ch] = 1'b1;
    iDivisor[ch*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  initial begin
    reset = 1'b1; iEn = 1'b0; iSync = 1'b0; iLoad = '0; iDivisor = '0;
    for (int i = 0; i < NCH; i++) begin
      m_ph[i] = 0; m_n[i] = DEF_DIV; m_sh[i] = DEF_DIV;
    end
    m_div = '0; m_tick = '0; m_pend = '0;
    step();
    chk("rst_div", oDiv, 0);
    chk("rst_tick", oTick, 0);

    // 1: defaults, N=2 everywhere
    iEn = 1'b1;
    step();
    chk("first_tick", oTick, 4'hF);
    chk("first_div", oDiv, 4'hF);
    step();
    chk("n2_low", oDiv, 4'h0);
    run(8);

    // 2: ch1 -> 5, loaded while its count sits at 0
    while (m_ph[1] != 0) step();
    load(1, 5);
    step();
    chk("pend_set", oPending, 4'b0010);
    step();
    chk("pend_clr", oPending, 4'b0000);
    run(15);

    // 3: ch2 -> 3, 1, 0
    load(2, 3); run(10);
    load(2, 1); run(6);
    load(2, 0); run(3);
    for (int k = 0; k < 6; k++) begin iEn = k[0]; step(); end
    iEn = 1'b1;

    // 4: out-of-phase channels, then sync
    load(0, 2); step();
    load(1, 4); run(2);
    load(2, 8); run(3);
    load(3, 6); run(13);
    iSync = 1'b1; step();
    chk("sync_tick", oTick, 4'hF);
    chk("sync_div", oDiv, 4'hF);
    run(30);

    // 5: freeze for 7 cycles with a load on ch0
    run(1);
    iEn = 1'b0; load(0, 4);
    run(7);
    chk("frz_tick", oTick, 0);
    iEn = 1'b1; run(12);

    // 6: reset mid-period with loads pending
    iEn = 1'b0; load(1, 7); load(3, 9); step();
    reset = 1'b1; step();
    chk("rst2_pend", oPending, 0);
    iEn = 1'b1; run(6);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      iEn   = ($urandom_range(0, 9) != 0);
      iSync = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 19) == 0)
          load(i, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
